// File: rtl/procyon_types.sv
// rtl/procyon_types.sv - shared integer-pipeline types and constants
package procyon_types;

    typedef enum logic [3:0] {
        ALU_FUNC_ADD  = 4'd0,
        ALU_FUNC_SUB  = 4'd1,
        ALU_FUNC_AND  = 4'd2,
        ALU_FUNC_OR   = 4'd3,
        ALU_FUNC_XOR  = 4'd4,
        ALU_FUNC_SLL  = 4'd5,
        ALU_FUNC_SRL  = 4'd6,
        ALU_FUNC_SRA  = 4'd7,
        ALU_FUNC_EQ   = 4'd8,
        ALU_FUNC_NE   = 4'd9,
        ALU_FUNC_LT   = 4'd10,
        ALU_FUNC_GE   = 4'd11,
        ALU_FUNC_LTU  = 4'd12,
        ALU_FUNC_GEU  = 4'd13
    } procyon_alu_func_t;

    typedef logic [4:0] procyon_shamt_t;

    localparam int IEU_LINK_OFFSET = 4;

endpackage

// File: rtl/ieu_alu.sv
// rtl/ieu_alu.sv - combinational integer ALU with separate compare flag
module ieu_alu
    import procyon_types::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  procyon_alu_func_t       i_alu_func,
    input  logic [DATA_WIDTH-1:0]   i_a,
    input  logic [DATA_WIDTH-1:0]   i_b,
    input  procyon_shamt_t          i_shamt,
    output logic [DATA_WIDTH-1:0]   o_result,
    output logic                    o_cmp
);

    always_comb begin
        o_cmp = 1'b0;
        unique case (i_alu_func)
            ALU_FUNC_EQ:  o_cmp = (i_a == i_b);
            ALU_FUNC_NE:  o_cmp = (i_a != i_b);
            ALU_FUNC_LT:  o_cmp = ($signed(i_a) <  $signed(i_b));
            ALU_FUNC_GE:  o_cmp = ($signed(i_a) >= $signed(i_b));
            ALU_FUNC_LTU: o_cmp = (i_a <  i_b);
            ALU_FUNC_GEU: o_cmp = (i_a >= i_b);
            default:      o_cmp = 1'b0;
        endcase
    end

    always_comb begin
        o_result = '0;
        unique case (i_alu_func)
            ALU_FUNC_ADD: o_result = i_a + i_b;
            ALU_FUNC_SUB: o_result = i_a - i_b;
            ALU_FUNC_AND: o_result = i_a & i_b;
            ALU_FUNC_OR:  o_result = i_a | i_b;
            ALU_FUNC_XOR: o_result = i_a ^ i_b;
            ALU_FUNC_SLL: o_result = i_a << i_shamt;
            ALU_FUNC_SRL: o_result = i_a >> i_shamt;
            ALU_FUNC_SRA: o_result = $unsigned($signed(i_a) >>> i_shamt);
            default:      o_result = {{(DATA_WIDTH-1){1'b0}}, o_cmp};
        endcase
    end

endmodule

// File: rtl/ieu_ex.sv
// rtl/ieu_ex.sv - integer execute stage with one-entry CDB output register
module ieu_ex
    import procyon_types::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TAG_WIDTH  = 6
) (
    input  logic                    clk,
    input  logic                    i_rst,
    input  logic                    i_flush,
    input  logic                    i_valid,
    input  procyon_alu_func_t       i_alu_func,
    input  logic [DATA_WIDTH-1:0]   i_src_a,
    input  logic [DATA_WIDTH-1:0]   i_src_b,
    input  logic [ADDR_WIDTH-1:0]   i_iaddr,
    input  logic [DATA_WIDTH-1:0]   i_imm_b,
    input  procyon_shamt_t          i_shamt,
    input  logic [TAG_WIDTH-1:0]    i_tag,
    input  logic                    i_jmp,
    input  logic                    i_br,
    output logic                    o_ready,
    input  logic                    i_cdb_gnt,
    output logic                    o_cdb_req,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic [TAG_WIDTH-1:0]    o_tag,
    output logic                    o_redirect,
    output logic [ADDR_WIDTH-1:0]   o_addr
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [TAG_WIDTH-1:0]    tag_q;
    logic                    redirect_q, redirect_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;

    logic [DATA_WIDTH-1:0]   alu_result;
    logic                    alu_cmp;
    logic [ADDR_WIDTH-1:0]   link_addr;
    logic [ADDR_WIDTH-1:0]   jmp_addr;
    logic [ADDR_WIDTH-1:0]   br_addr;
    logic [DATA_WIDTH-1:0]   jmp_sum;
    logic                    accept;

    ieu_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .i_alu_func (i_alu_func),
        .i_a        (i_src_a),
        .i_b        (i_src_b),
        .i_shamt    (i_shamt),
        .o_result   (alu_result),
        .o_cmp      (alu_cmp)
    );

    assign o_ready   = (state_q == ST_EMPTY) || i_cdb_gnt;
    assign accept    = i_valid && o_ready && !i_flush;

    // Jump target drops bit 0 so JALR lands on a halfword boundary.
    assign jmp_sum   = i_src_a + i_src_b;
    assign link_addr = i_iaddr + ADDR_WIDTH'(IEU_LINK_OFFSET);
    assign jmp_addr  = ADDR_WIDTH'(jmp_sum) & ~ADDR_WIDTH'(1);
    assign br_addr   = i_iaddr + ADDR_WIDTH'(i_imm_b);

    always_comb begin
        data_d     = alu_result;
        redirect_d = 1'b0;
        addr_d     = link_addr;
        if (i_jmp) begin
            data_d     = DATA_WIDTH'(link_addr);
            redirect_d = 1'b1;
            addr_d     = jmp_addr;
        end else if (i_br) begin
            data_d     = '0;
            redirect_d = alu_cmp;
            addr_d     = br_addr;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_flush) begin
            state_d = ST_EMPTY;
        end else if (accept) begin
            state_d = ST_FULL;
        end else if ((state_q == ST_FULL) && i_cdb_gnt) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q    <= ST_EMPTY;
            data_q     <= '0;
            tag_q      <= '0;
            redirect_q <= 1'b0;
            addr_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q     <= data_d;
                tag_q      <= i_tag;
                redirect_q <= redirect_d;
                addr_q     <= addr_d;
            end
        end
    end

    assign o_cdb_req  = (state_q == ST_FULL);
    assign o_data     = data_q;
    assign o_tag      = tag_q;
    assign o_redirect = redirect_q;
    assign o_addr     = addr_q;

endmodule

// File: tb/tb_ieu_ex.sv
// tb/tb_ieu_ex.sv - directed self-checking bench for ieu_ex
module tb_ieu_ex;
    import procyon_types::*;

    logic              clk = 1'b0;
    logic              i_rst, i_flush, i_valid;
    procyon_alu_func_t i_alu_func;
    logic [31:0]       i_src_a, i_src_b, i_iaddr, i_imm_b;
    procyon_shamt_t    i_shamt;
    logic [5:0]        i_tag;
    logic              i_jmp, i_br, o_ready, i_cdb_gnt, o_cdb_req, o_redirect;
    logic [31:0]       o_data, o_addr;
    logic [5:0]        o_tag;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ieu_ex #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TAG_WIDTH(6)) dut (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_flush    (i_flush),
        .i_valid    (i_valid),
        .i_alu_func (i_alu_func),
        .i_src_a    (i_src_a),
        .i_src_b    (i_src_b),
        .i_iaddr    (i_iaddr),
        .i_imm_b    (i_imm_b),
        .i_shamt    (i_shamt),
        .i_tag      (i_tag),
        .i_jmp      (i_jmp),
        .i_br       (i_br),
        .o_ready    (o_ready),
        .i_cdb_gnt  (i_cdb_gnt),
        .o_cdb_req  (o_cdb_req),
        .o_data     (o_data),
        .o_tag      (o_tag),
        .o_redirect (o_redirect),
        .o_addr     (o_addr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input procyon_alu_func_t f, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ia, input logic [31:0] imm, input logic [4:0] sh,
                      input logic [5:0] t, input logic j, input logic br);
        i_valid    = 1'b1;
        i_alu_func = f;
        i_src_a    = a;
        i_src_b    = b;
        i_iaddr    = ia;
        i_imm_b    = imm;
        i_shamt    = sh;
        i_tag      = t;
        i_jmp      = j;
        i_br       = br;
    endtask

    task automatic chk_out(input string tag, input logic req, input logic [31:0] d,
                           input logic [5:0] t, input logic rd, input logic [31:0] ad);
        chk({tag, ".req"},      {63'd0, o_cdb_req},  {63'd0, req});
        chk({tag, ".data"},     {32'd0, o_data},     {32'd0, d});
        chk({tag, ".tag"},      {58'd0, o_tag},      {58'd0, t});
        chk({tag, ".redirect"}, {63'd0, o_redirect}, {63'd0, rd});
        chk({tag, ".addr"},     {32'd0, o_addr},     {32'd0, ad});
    endtask

    initial begin
        i_rst = 1'b1; i_flush = 1'b0; i_cdb_gnt = 1'b0;
        op(ALU_FUNC_ADD, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 6'd0, 1'b0, 1'b0);
        i_valid = 1'b0;
        step();
        step();
        chk_out("reset", 1'b0, 32'd0, 6'd0, 1'b0, 32'd0);
        i_rst = 1'b0;
        #1;
        chk("reset.ready", {63'd0, o_ready}, 64'd1);

        i_cdb_gnt = 1'b1;
        op(ALU_FUNC_ADD, 32'h7FFF_FFFF, 32'd1, 32'h0, 32'h0, 5'd0, 6'd1, 1'b0, 1'b0);
        step();
        chk_out("add", 1'b1, 32'h8000_0000, 6'd1, 1'b0, 32'h4);
        chk("add.ready", {63'd0, o_ready}, 64'd1);

        op(ALU_FUNC_SRA, 32'h8000_0000, 32'd0, 32'h10, 32'h0, 5'd4, 6'd2, 1'b0, 1'b0);
        step();
        chk_out("sra", 1'b1, 32'hF800_0000, 6'd2, 1'b0, 32'h14);

        op(ALU_FUNC_SRL, 32'h8000_0000, 32'd0, 32'h10, 32'h0, 5'd4, 6'd3, 1'b0, 1'b0);
        step();
        chk_out("srl", 1'b1, 32'h0800_0000, 6'd3, 1'b0, 32'h14);

        op(ALU_FUNC_LT, 32'hFFFF_FFFF, 32'd0, 32'h100, 32'h20, 5'd0, 6'd4, 1'b0, 1'b1);
        step();
        chk_out("blt", 1'b1, 32'h0, 6'd4, 1'b1, 32'h120);

        op(ALU_FUNC_LTU, 32'hFFFF_FFFF, 32'd0, 32'h100, 32'h20, 5'd0, 6'd5, 1'b0, 1'b1);
        step();
        chk_out("bltu", 1'b1, 32'h0, 6'd5, 1'b0, 32'h120);

        op(ALU_FUNC_ADD, 32'h203, 32'd4, 32'h40, 32'h0, 5'd0, 6'd6, 1'b1, 1'b0);
        step();
        chk_out("jalr", 1'b1, 32'h44, 6'd6, 1'b1, 32'h206);

        i_cdb_gnt = 1'b0;
        op(ALU_FUNC_SUB, 32'h10, 32'h3, 32'h80, 32'h0, 5'd0, 6'd7, 1'b0, 1'b0);
        #1;
        chk("stall.ready0", {63'd0, o_ready}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("stall%0d", i), 1'b1, 32'h44, 6'd6, 1'b1, 32'h206);
            chk($sformatf("stall%0d.ready", i), {63'd0, o_ready}, 64'd0);
        end
        i_cdb_gnt = 1'b1;
        #1;
        chk("release.ready", {63'd0, o_ready}, 64'd1);
        step();
        chk_out("release", 1'b1, 32'h0000_000D, 6'd7, 1'b0, 32'h84);

        i_valid = 1'b0;
        step();
        chk("drain.req", {63'd0, o_cdb_req}, 64'd0);
        step();
        chk("empty_gnt.req", {63'd0, o_cdb_req}, 64'd0);

        i_cdb_gnt = 1'b0;
        op(ALU_FUNC_XOR, 32'hF0, 32'hFF, 32'h200, 32'h0, 5'd0, 6'd8, 1'b0, 1'b0);
        step();
        chk_out("xor", 1'b1, 32'h0F, 6'd8, 1'b0, 32'h204);
        i_flush = 1'b1; i_cdb_gnt = 1'b1;
        op(ALU_FUNC_ADD, 32'h1, 32'h1, 32'h300, 32'h0, 5'd0, 6'd9, 1'b0, 1'b0);
        step();
        chk("flush.req", {63'd0, o_cdb_req}, 64'd0);
        i_flush = 1'b0; i_valid = 1'b0;
        step();
        chk("post_flush.req", {63'd0, o_cdb_req}, 64'd0);

        op(ALU_FUNC_EQ, 32'd5, 32'd5, 32'h0, 32'h0, 5'd0, 6'd10, 1'b0, 1'b0);
        step();
        chk("eq.data", {32'd0, o_data}, 64'd1);
        op(ALU_FUNC_NE, 32'd5, 32'd5, 32'h0, 32'h0, 5'd0, 6'd11, 1'b0, 1'b0);
        step();
        chk("ne.data", {32'd0, o_data}, 64'd0);
        op(ALU_FUNC_GE, 32'hFFFF_FFFE, 32'd1, 32'h0, 32'h0, 5'd0, 6'd12, 1'b0, 1'b0);
        step();
        chk("ge.data", {32'd0, o_data}, 64'd0);
        op(ALU_FUNC_GEU, 32'hFFFF_FFFE, 32'd1, 32'h0, 32'h0, 5'd0, 6'd13, 1'b0, 1'b0);
        step();
        chk("geu.data", {32'd0, o_data}, 64'd1);
        op(ALU_FUNC_SLL, 32'd1, 32'd0, 32'h0, 32'h0, 5'd31, 6'd14, 1'b0, 1'b0);
        step();
        chk("sll.data", {32'd0, o_data}, 64'h8000_0000);
        op(ALU_FUNC_SUB, 32'd0, 32'd1, 32'h0, 32'h0, 5'd0, 6'd15, 1'b0, 1'b0);
        step();
        chk("sub_wrap.data", {32'd0, o_data}, 64'hFFFF_FFFF);
        op(ALU_FUNC_AND, 32'hF0F0, 32'hFF00, 32'h0, 32'h0, 5'd0, 6'd16, 1'b0, 1'b0);
        step();
        chk("and.data", {32'd0, o_data}, 64'hF000);
        op(ALU_FUNC_ADD, 32'd3, 32'd4, 32'h500, 32'h0, 5'd0, 6'd17, 1'b0, 1'b0);
        step();
        chk_out("pre_rst", 1'b1, 32'd7, 6'd17, 1'b0, 32'h504);

        i_rst = 1'b1; i_flush = 1'b1;
        op(ALU_FUNC_OR, 32'h1, 32'h2, 32'h600, 32'h0, 5'd0, 6'd18, 1'b0, 1'b0);
        step();
        chk_out("mid_rst", 1'b0, 32'd0, 6'd0, 1'b0, 32'd0);
        i_rst = 1'b0; i_flush = 1'b0; i_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
